// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit adder split into STAGES registered ripple-carry slices with valid/ready handshake.
// Define PIPE_RIPPLE_ADDER_SUB_EN to add a sub port that selects a - b.
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned SLICE = WIDTH / STAGES;

    logic adv;

    // One stall signal freezes every stage, bubbles included.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    function automatic logic [SLICE:0] ripple(input logic [SLICE-1:0] x,
                                              input logic [SLICE-1:0] y,
                                              input logic             ci);
        logic [SLICE-1:0] s;
        logic             c;
        c = ci;
        for (int i = 0; i < int'(SLICE); i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * SLICE;

        logic                  vld_in;
        logic                  cy_in;
        logic                  md;
        logic [WIDTH-LO-1:0]   src_a;
        logic [WIDTH-LO-1:0]   src_b;
        logic [SLICE-1:0]      y;
        logic [SLICE:0]        r;
        logic [LO+SLICE-1:0]   s_d;
        logic                  vld_q;
        logic                  cy_q;
        logic [LO+SLICE-1:0]   s_q;

        if (k == 0) begin : g_src
            assign vld_in = in_valid;
            assign src_a  = a;
            assign src_b  = b;
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
            assign md     = sub;
`else
            assign md     = 1'b0;
`endif
            // Subtract is a + ~b + 1, so the external carry is overridden.
            assign cy_in  = md | cin;
            assign s_d    = r[SLICE-1:0];
        end else begin : g_src
            assign vld_in = g_stage[k-1].vld_q;
            assign src_a  = g_stage[k-1].g_fwd.fa_q;
            assign src_b  = g_stage[k-1].g_fwd.fb_q;
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
            assign md     = g_stage[k-1].g_fwd.md_q;
`else
            assign md     = 1'b0;
`endif
            assign cy_in  = g_stage[k-1].cy_q;
            assign s_d    = {r[SLICE-1:0], g_stage[k-1].s_q};
        end

        assign y = md ? ~src_b[SLICE-1:0] : src_b[SLICE-1:0];
        assign r = ripple(src_a[SLICE-1:0], y, cy_in);

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                s_q   <= '0;
            end else if (adv) begin
                vld_q <= vld_in;
                cy_q  <= r[SLICE];
                s_q   <= s_d;
            end
        end

        // Upper operand slices (and mode) travel with the operation until consumed.
        if (k + 1 < STAGES) begin : g_fwd
            logic [WIDTH-LO-SLICE-1:0] fa_q;
            logic [WIDTH-LO-SLICE-1:0] fb_q;
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
            logic                      md_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    md_q <= 1'b0;
                end else if (adv) begin
                    md_q <= md;
                end
            end
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    fa_q <= '0;
                    fb_q <= '0;
                end else if (adv) begin
                    fa_q <= src_a[WIDTH-LO-1:SLICE];
                    fb_q <= src_b[WIDTH-LO-1:SLICE];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].cy_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: three configurations, directed and random.
// Define PIPE_RIPPLE_ADDER_SUB_EN to also exercise the subtract mode.
module tb_pipelined_ripple_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic        ci = 1'b0;
    logic        ordy = 1'b1;
    logic        sub_s = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;

    logic        ir2, ov2, co2;
    logic [7:0]  s2;
    logic        ir1, ov1, co1;
    logic [7:0]  s1;
    logic        ir4, ov4, co4;
    logic [31:0] s4;

    int total = 0;
    int bad = 0;

    logic [32:0] q[$];
    logic [63:0] r, ra, rb;
    logic        hold;
    logic [8:0]  held;

    logic [7:0]  st_a [3] = '{8'h10, 8'h7F, 8'hF0};
    logic [7:0]  st_b [3] = '{8'h20, 8'h01, 8'h0F};
    logic        st_c [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0]  st_s [3] = '{8'h30, 8'h81, 8'hFF};

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir2), .a(a32[7:0]), .b(b32[7:0]),
        .cin(ci),
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .out_valid(ov2), .out_ready(ordy), .sum(s2), .cout(co2)
    );

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir1), .a(a32[7:0]), .b(b32[7:0]),
        .cin(ci),
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .out_valid(ov1), .out_ready(ordy), .sum(s1), .cout(co1)
    );

    pipelined_ripple_adder #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir4), .a(a32), .b(b32),
        .cin(ci),
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .out_valid(ov4), .out_ready(ordy), .sum(s4), .cout(co4)
    );

    // Result as (w+1)-bit number: bit w is cout.
    function automatic logic [63:0] model(input int unsigned w, input logic [31:0] x,
                                          input logic [31:0] y, input logic c, input logic sb);
        longint unsigned m;
        longint unsigned res;
        m = (64'd1 << w) - 64'd1;
        if (sb) res = (64'(x) & m) + (m + 64'd1) - (64'(y) & m);
        else    res = (64'(x) & m) + (64'(y) & m) + 64'(c);
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation through all three DUTs; checks latency and result.
    task automatic op_all(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input logic sb);
        int          l1, l2, l4;
        logic [7:0]  g1, g2;
        logic [31:0] g4;
        logic        h1, h2, h4;
        logic [63:0] e8, e32;
        l1 = 0; l2 = 0; l4 = 0;
        g1 = '0; g2 = '0; g4 = '0; h1 = 0; h2 = 0; h4 = 0;
        ordy = 1; iv = 1; a32 = x; b32 = y; ci = c; sub_s = sb;
        for (int e = 1; e <= 6; e++) begin
            tick();
            iv = 0;
            if (ov1 && l1 == 0) begin l1 = e; g1 = s1; h1 = co1; end
            if (ov2 && l2 == 0) begin l2 = e; g2 = s2; h2 = co2; end
            if (ov4 && l4 == 0) begin l4 = e; g4 = s4; h4 = co4; end
        end
        e8  = model(8, x, y, c, sb);
        e32 = model(32, x, y, c, sb);
        check({tag, "_lat_s1"}, 64'(l1), 64'd1);
        check({tag, "_sum_s1"}, 64'(g1), e8 & 64'hFF);
        check({tag, "_cout_s1"}, 64'(h1), (e8 >> 8) & 64'd1);
        check({tag, "_lat_s2"}, 64'(l2), 64'd2);
        check({tag, "_sum_s2"}, 64'(g2), e8 & 64'hFF);
        check({tag, "_cout_s2"}, 64'(h2), (e8 >> 8) & 64'd1);
        check({tag, "_lat_w32"}, 64'(l4), 64'd4);
        check({tag, "_sum_w32"}, 64'(g4), e32 & 64'hFFFF_FFFF);
        check({tag, "_cout_w32"}, 64'(h4), (e32 >> 32) & 64'd1);
    endtask

    initial begin
        // Reset values
        rst = 1; ordy = 0;
        tick();
        tick();
        check("rst_ov_s2", ov2, 0);   check("rst_sum_s2", s2, 0);   check("rst_cout_s2", co2, 0);
        check("rst_ov_s1", ov1, 0);   check("rst_sum_s1", s1, 0);   check("rst_cout_s1", co1, 0);
        check("rst_ov_w32", ov4, 0);  check("rst_sum_w32", s4, 0);  check("rst_cout_w32", co4, 0);
        rst = 0;
        tick();
        check("ready_after_rst_s2", ir2, 1);
        check("ready_after_rst_s1", ir1, 1);
        check("ready_after_rst_w32", ir4, 1);

        // Carry ripple, degenerate and wide cases
        op_all("carry", 32'hFF, 32'h01, 1'b0, 1'b0);
        op_all("deg", 32'h80, 32'h80, 1'b0, 1'b0);
        op_all("wide", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        check("wide_const_sum", s4, 32'h0);
        check("wide_const_cout", co4, 1);

        // Streaming on the 8/2 DUT
        ordy = 1;
        for (int e = 0; e < 6; e++) begin
            if (e < 3) begin
                iv = 1; a32 = 32'(st_a[e]); b32 = 32'(st_b[e]); ci = st_c[e];
            end else begin
                iv = 0;
            end
            tick();
            check("stream_ov", ov2, 64'(e >= 1 && e <= 3));
            if (e >= 1 && e <= 3) begin
                check("stream_sum", s2, st_s[e-1]);
                check("stream_cout", co2, 0);
            end
        end

        // Backpressure with two results in flight
        ra = model(8, 32'h3C, 32'h41, 1'b0, 1'b0);
        rb = model(8, 32'hC8, 32'h64, 1'b1, 1'b0);
        ordy = 0; iv = 1; a32 = 32'h3C; b32 = 32'h41; ci = 0;
        tick();
        iv = 1; a32 = 32'hC8; b32 = 32'h64; ci = 1;
        tick();
        iv = 0;
        for (int i = 0; i < 4; i++) begin
            check("bp_ready", ir2, 0);
            check("bp_ov", ov2, 1);
            check("bp_hold", {co2, s2}, ra & 64'h1FF);
            tick();
        end
        ordy = 1;
        #1;
        check("bp_release_ready", ir2, 1);
        check("bp_first", {ov2, co2, s2}, 64'h200 | (ra & 64'h1FF));
        tick();
        check("bp_second", {ov2, co2, s2}, 64'h200 | (rb & 64'h1FF));
        tick();
        check("bp_no_dup", ov2, 0);

        // Reset while an operation is in flight
        ordy = 1; iv = 1; a32 = 32'hAA; b32 = 32'h55; ci = 0;
        tick();
        iv = 0; rst = 1;
        tick();
        check("midrst_s2", {ov2, co2, s2}, 0);
        check("midrst_s1", {ov1, co1, s1}, 0);
        check("midrst_w32", {ov4, co4, s4}, 0);
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_emit", {ov1, ov2, ov4}, 0);
        end

`ifdef PIPE_RIPPLE_ADDER_SUB_EN
        op_all("sub_borrow", 32'h05, 32'h07, 1'b0, 1'b1);
        op_all("sub_noborrow", 32'h07, 32'h05, 1'b1, 1'b1);
`endif

        // Random stream with backpressure on the 8/2 DUT against a queue model
        hold = 0; held = '0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (hold) begin
                check("rnd_hold_ov", ov2, 1);
                check("rnd_hold_data", {co2, s2}, held);
            end
            iv   = ($urandom_range(0, 3) != 0);
            a32  = $urandom;
            b32  = $urandom;
            ci   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
`ifdef PIPE_RIPPLE_ADDER_SUB_EN
            sub_s = 1'($urandom_range(0, 1));
`endif
            #1;
            check("rnd_ready", ir2, !ov2 || ordy);
            if (ov2 && ordy) begin
                check("rnd_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    r = 64'(q.pop_front());
                    check("rnd_result", {co2, s2}, r & 64'h1FF);
                end
            end
            if (iv && ir2) q.push_back(33'(model(8, a32, b32, ci, sub_s)));
            hold = ov2 && !ordy;
            held = {co2, s2};
        end
        tick();
        iv = 0; ordy = 1;
        #1;
        for (int n = 0; n < 8; n++) begin
            if (ov2) begin
                check("drain_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    r = 64'(q.pop_front());
                    check("drain_result", {co2, s2}, r & 64'h1FF);
                end
            end
            tick();
        end
        check("drain_empty", 64'(q.size()), 0);
        check("drain_ov", ov2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
